sliced_alu: RTL and testbench

- Multi-cycle, parametrised successor of the fixed 32-bit two-slice ALU.
- Processes a WIDTH-bit operation one SLICE-bit slice per clock: an internal carry register chains the slices, and the final slice's set is fed back into bit 0 for SLT.
- Valid/ready handshake on input and output.
- Sits between the register-file read stage and writeback in the multi-cycle datapath.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_slice.sv | 53 +++++
 rtl/sliced_alu.sv | 162 ++++++++++++++++
 tb/tb_sliced_alu.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg -- shared definitions for the slice-serial ALU (sliced_alu).
//
// Contents:
//   ALU_* op-code constants (3-bit op field of sliced_alu / alu_slice)
//   state_e  : control state of sliced_alu (S_IDLE, S_RUN, S_DONE)
//   helpers  : op-class predicates used by the top level
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  // Only decoded when SLICED_ALU_NOR_EN is defined; otherwise unsupported.
  localparam logic [2:0] ALU_NOR = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Ops whose signed overflow is reported.
  function automatic logic is_add_sub(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

  // Ops whose signed-less-than flag is meaningful.
  function automatic logic is_sub_slt(input logic [2:0] op);
    return (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// -----------------------------------------------------------------------------
// alu_slice -- combinational SLICE-bit ALU slice, time-multiplexed by sliced_alu.
//
// Optional feature: SLICED_ALU_NOR_EN enables op 100 = NOR.
//
// Ports:
//   a, b          in   SLICE  operand slices
//   cin           in   1      carry into bit 0 of this slice
//   op            in   3      ALU op code (see alu_pkg)
//   result        out  SLICE  slice result (0 for unsupported ops)
//   cout          out  1      carry out of the slice MSB
//   msb_carry_in  out  1      carry into the slice MSB (for overflow detection)
// -----------------------------------------------------------------------------
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  logic [2:0]       op,
  output logic [SLICE-1:0] result,
  output logic             cout,
  output logic             msb_carry_in
);

  logic [SLICE-1:0] b_eff;
  logic [SLICE:0]   sum;

  // op[2] selects subtraction: B is inverted here and the +1 arrives through
  // the carry chain, which the top seeds with op[2].
  assign b_eff        = op[2] ? ~b : b;
  assign sum          = {1'b0, a} + {1'b0, b_eff} + {{SLICE{1'b0}}, cin};
  assign cout         = sum[SLICE];
  assign msb_carry_in = a[SLICE-1] ^ b_eff[SLICE-1] ^ sum[SLICE-1];

  always_comb begin
    result = '0;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD,
      ALU_SUB,
      ALU_SLT: result = sum[SLICE-1:0];
`ifdef SLICED_ALU_NOR_EN
      ALU_NOR: result = ~(a | b);
`endif
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/sliced_alu.sv
// -----------------------------------------------------------------------------
// sliced_alu -- multi-cycle ALU processing one SLICE-bit slice per clock.
//
// Optional feature: SLICED_ALU_NOR_EN enables op 100 = NOR (see alu_slice).
//
// Parameters: WIDTH (multiple of SLICE), SLICE. NSLICE = WIDTH/SLICE RUN cycles.
//
// Ports:
//   clk, reset_n          rising-edge clock, synchronous active-low reset
//   a, b, op, in_valid    operands / op, captured when in_valid & in_ready
//   in_ready              high only in IDLE
//   result, set, zero,    registered outputs, valid while out_valid
//   overflow
//   out_valid, out_ready  output handshake; result held until out_ready
//
// Timing: accept at cycle 0, out_valid at cycle NSLICE+1, one op every
// NSLICE+2 cycles with out_ready tied high (no IDLE bypass).
// -----------------------------------------------------------------------------
module sliced_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             set,
  output logic             zero,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e           state_q,    state_d;
  logic [WIDTH-1:0] a_q,        a_d;
  logic [WIDTH-1:0] b_q,        b_d;
  logic [2:0]       op_q,       op_d;
  logic [IDXW-1:0]  idx_q,      idx_d;
  logic             carry_q,    carry_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic             set_q,      set_d;
  logic             overflow_q, overflow_d;

  logic [SLICE-1:0] slice_res;
  logic             slice_cout;
  logic             slice_msb_cin;
  logic             last_slice;
  logic             ovf_raw;

  // The single slice walks across the registered operands, one slice per cycle.
  alu_slice #(.SLICE(SLICE)) u_slice (
    .a            (a_q[idx_q*SLICE +: SLICE]),
    .b            (b_q[idx_q*SLICE +: SLICE]),
    .cin          (carry_q),
    .op           (op_q),
    .result       (slice_res),
    .cout         (slice_cout),
    .msb_carry_in (slice_msb_cin)
  );

  assign last_slice = (idx_q == IDXW'(NSLICE - 1));
  assign ovf_raw    = slice_msb_cin ^ slice_cout;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    result_d   = result_q;
    set_d      = set_q;
    overflow_d = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          idx_d   = '0;
          carry_d = op[2];  // +1 of the two's-complement negate for SUB/SLT
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        result_d[idx_q*SLICE +: SLICE] = slice_res;
        carry_d                        = slice_cout;
        if (last_slice) begin
          set_d      = is_sub_slt(op_q) ? (slice_res[SLICE-1] ^ ovf_raw) : 1'b0;
          overflow_d = is_add_sub(op_q) ? ovf_raw : 1'b0;
          // SLT replaces the difference so the flag is stable from the first
          // out_valid cycle.
          if (op_q == ALU_SLT) begin
            result_d = {{(WIDTH-1){1'b0}}, set_d};
          end
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the operand/op registers are deliberately left unreset; they are
      // always loaded on accept before being read, so reset only clears
      // control state and the visible outputs.
      state_q    <= S_IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      result_q   <= '0;
      set_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      result_q   <= result_d;
      set_q      <= set_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q  <= a_d;
    b_q  <= b_d;
    op_q <= op_d;
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign set       = set_q;
  assign overflow  = overflow_q;
  // Qualified by DONE so the flag reads 0 out of reset and between results.
  assign zero      = (state_q == S_DONE) && (result_q == '0);

endmodule

// File: tb/tb_sliced_alu.sv
// -----------------------------------------------------------------------------
// tb_sliced_alu -- self-checking bench for sliced_alu.
// Instance u_dut: WIDTH=32/SLICE=16; instance u_wide: WIDTH=64/SLICE=8.
// Expected values come from spec-level arithmetic in model() and constants.
// -----------------------------------------------------------------------------
module tb_sliced_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] a, b, result;
  logic [2:0]  op;
  logic        in_valid, in_ready, set, zero, overflow, out_valid, out_ready;

  logic [63:0] w_a, w_b, w_result;
  logic [2:0]  w_op;
  logic        w_in_valid, w_in_ready, w_set, w_zero, w_overflow, w_out_valid, w_out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sliced_alu #(.WIDTH(32), .SLICE(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .op(op), .in_valid(in_valid),
    .in_ready(in_ready), .result(result), .set(set), .zero(zero),
    .overflow(overflow), .out_valid(out_valid), .out_ready(out_ready)
  );

  sliced_alu #(.WIDTH(64), .SLICE(8)) u_wide (
    .clk(clk), .reset_n(reset_n), .a(w_a), .b(w_b), .op(w_op), .in_valid(w_in_valid),
    .in_ready(w_in_ready), .result(w_result), .set(w_set), .zero(w_zero),
    .overflow(w_overflow), .out_valid(w_out_valid), .out_ready(w_out_ready)
  );

  typedef struct {
    logic [31:0] result;
    logic        set, zero, ovf, rdy;
    int          lat;
  } obs_t;

  typedef struct {
    logic [31:0] result;
    logic        set, zero, ovf, chk_set;
  } exp_t;

  // Reference: results straight from the op definitions, 32-bit.
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, y);
    exp_t e;
    logic [31:0] r;
    logic        lt;
    lt = ($signed(x) < $signed(y));
    r  = '0;
    e.set = 1'b0; e.ovf = 1'b0; e.chk_set = 1'b1;
    case (o)
      ALU_AND: begin r = x & y; e.chk_set = 1'b0; end
      ALU_OR:  begin r = x | y; e.chk_set = 1'b0; end
      ALU_ADD: begin
        r = x + y; e.chk_set = 1'b0;
        e.ovf = (x[31] == y[31]) && (r[31] != x[31]);
      end
      ALU_SUB: begin
        r = x - y; e.set = lt;
        e.ovf = (x[31] != y[31]) && (r[31] != x[31]);
      end
      ALU_SLT: begin e.set = lt; r = lt ? 32'd1 : 32'd0; end
`ifdef SLICED_ALU_NOR_EN
      ALU_NOR: begin r = ~(x | y); e.chk_set = 1'b0; end
`endif
      default: r = '0;
    endcase
    e.result = r;
    e.zero   = (r == 32'd0);
    return e;
  endfunction

  // Drives one op on u_dut from a negedge; returns at the first negedge with
  // out_valid (lat = cycles after the accept cycle, -1 on timeout).
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, y,
                        input logic release_out, output obs_t ob);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (in_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL in_ready_wait got=%b want=1", in_ready);
    end
    a = x; b = y; op = o; in_valid = 1'b1; out_ready = release_out;
    @(posedge clk);
    n = 0;
    do begin @(negedge clk); in_valid = 1'b0; n++; end
    while (out_valid !== 1'b1 && n < 20);
    ob.lat    = (out_valid === 1'b1) ? n : -1;
    ob.result = result;
    ob.set    = set;
    ob.zero   = zero;
    ob.ovf    = overflow;
    ob.rdy    = in_ready;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_a = '0; w_b = '0; w_op = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, result, set, zero, overflow} !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
      failures++;
      $display("FAIL reset rdy=%b vld=%b res=%h set=%b zero=%b ovf=%b want rdy=1 vld=0 res=0 flags=0",
               in_ready, out_valid, result, set, zero, overflow);
    end
    checks++;
    if ({w_in_ready, w_out_valid, w_result} !== {1'b1, 1'b0, 64'd0}) begin
      failures++;
      $display("FAIL reset_wide rdy=%b vld=%b res=%h want 1 0 0", w_in_ready, w_out_valid, w_result);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, r;
    logic        s, z, v, cs;
  } vec_t;

  vec_t vecs [9] = '{
    '{ALU_ADD, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0},
    '{ALU_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1, 1'b1},
    '{ALU_SUB, 32'd5,        32'd5,        32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1},
    '{ALU_SLT, 32'hFFFFFFFE, 32'h00000003, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1},
    '{ALU_SLT, 32'h00000003, 32'hFFFFFFFE, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1},
    '{ALU_OR,  32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0},
    '{ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b0},
    '{3'b011,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1},
    '{3'b101,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1}
  };

  task automatic test_directed();
    obs_t ob;
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, ob);
      checks++;
      if (ob.result !== vecs[i].r || ob.zero !== vecs[i].z || ob.ovf !== vecs[i].v) begin
        failures++;
        $display("FAIL directed[%0d] res=%h zero=%b ovf=%b want res=%h zero=%b ovf=%b",
                 i, ob.result, ob.zero, ob.ovf, vecs[i].r, vecs[i].z, vecs[i].v);
      end
      if (vecs[i].cs) begin
        checks++;
        if (ob.set !== vecs[i].s) begin
          failures++;
          $display("FAIL directed_set[%0d] got=%b want=%b", i, ob.set, vecs[i].s);
        end
      end
      checks++;
      if (ob.lat != 3) begin
        failures++;
        $display("FAIL directed_latency[%0d] got=%0d want=3", i, ob.lat);
      end
    end
  endtask

  task automatic test_hold();
    obs_t ob;
    run_op(ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, ob);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (result !== 32'hF000F000 || out_valid !== 1'b1 || in_ready !== 1'b0 || zero !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d] res=%h vld=%b rdy=%b zero=%b want F000F000 1 0 0",
                 i, result, out_valid, in_ready, zero);
      end
      // Offer a conflicting op mid-hold; it must be ignored.
      if (i == 1) begin a = 32'd7; b = 32'd9; op = ALU_ADD; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_ignored_input vld=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    obs_t ob;
    a = 32'h11111111; b = 32'h22222222; op = ALU_ADD; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrun_busy rdy=%b want 0", in_ready);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0) begin
      failures++;
      $display("FAIL midrun_reset rdy=%b vld=%b res=%h want 1 0 0", in_ready, out_valid, result);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrun_discard vld=%b want 0", out_valid);
    end
    run_op(ALU_OR, 32'h1, 32'h2, 1'b1, ob);
    checks++;
    if (ob.result !== 32'h3 || ob.lat != 3) begin
      failures++;
      $display("FAIL midrun_after res=%h lat=%0d want 3 lat=3", ob.result, ob.lat);
    end
  endtask

  task automatic test_back_to_back();
    obs_t ob;
    for (int i = 0; i < 4; i++) begin
      run_op(ALU_ADD, 32'(i * 3), 32'd100, 1'b1, ob);
      checks++;
      if (ob.rdy !== 1'b0 || ob.result !== 32'(i * 3 + 100)) begin
        failures++;
        $display("FAIL b2b_done[%0d] rdy=%b res=%h want rdy=0 res=%h", i, ob.rdy, ob.result, i * 3 + 100);
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL b2b_idle[%0d] rdy=%b vld=%b want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random();
    obs_t        ob;
    exp_t        e;
    logic [2:0]  o;
    logic [31:0] x, y;
    logic [31:0] edges [4] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      x = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 7) == 0) y = x;
      e = model(o, x, y);
      run_op(o, x, y, 1'b1, ob);
      checks++;
      if (ob.result !== e.result || ob.zero !== e.zero || ob.ovf !== e.ovf || ob.lat != 3) begin
        failures++;
        $display("FAIL random[%0d] op=%b a=%h b=%h res=%h zero=%b ovf=%b lat=%0d want res=%h zero=%b ovf=%b lat=3",
                 i, o, x, y, ob.result, ob.zero, ob.ovf, ob.lat, e.result, e.zero, e.ovf);
      end
      if (e.chk_set) begin
        checks++;
        if (ob.set !== e.set) begin
          failures++;
          $display("FAIL random_set[%0d] op=%b a=%h b=%h got=%b want=%b", i, o, x, y, ob.set, e.set);
        end
      end
    end
  endtask

  task automatic run_wide(input logic [2:0] o, input logic [63:0] x, y,
                          output logic [63:0] r, output logic z, v, output int lat);
    int n;
    n = 0;
    while (w_in_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    w_a = x; w_b = y; w_op = o; w_in_valid = 1'b1;
    @(posedge clk);
    n = 0;
    do begin @(negedge clk); w_in_valid = 1'b0; n++; end
    while (w_out_valid !== 1'b1 && n < 40);
    lat = (w_out_valid === 1'b1) ? n : -1;
    r = w_result; z = w_zero; v = w_overflow;
  endtask

  task automatic test_wide();
    logic [63:0] r, nor_exp;
    logic        z, v, nor_z;
    int          lat;
    run_wide(ALU_ADD, 64'h7FFFFFFFFFFFFFFF, 64'h1, r, z, v, lat);
    checks++;
    if (r !== 64'h8000000000000000 || v !== 1'b1 || z !== 1'b0 || lat != 9) begin
      failures++;
      $display("FAIL wide_add res=%h ovf=%b zero=%b lat=%0d want 8000000000000000 1 0 lat=9", r, v, z, lat);
    end
`ifdef SLICED_ALU_NOR_EN
    nor_exp = '1; nor_z = 1'b0;
`else
    nor_exp = '0; nor_z = 1'b1;
`endif
    run_wide(3'b100, 64'h0, 64'h0, r, z, v, lat);
    checks++;
    if (r !== nor_exp || z !== nor_z || v !== 1'b0 || lat != 9) begin
      failures++;
      $display("FAIL wide_nor res=%h zero=%b ovf=%b lat=%0d want %h %b 0 lat=9", r, z, v, lat, nor_exp, nor_z);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
